mmio_bridge_multi: RTL and testbench
====================================

// Module: mmio_bridge_multi
// PURPOSE
//  Multi-region MMIO bridge between the core MEM stage and N peripheral channels, with wait states.
//  Decodes the MEM-stage address into one of N_REGIONS windows and drives a per-channel select.
//  Holds the access until that channel's bus_ready; stalls the pipeline (core_stall) meanwhile.
//  Gives up on a dead device after a timeout. Replaces the fixed single-window, zero-wait MMIO path.
// PARAMETERS
//  N_REGIONS        4             number of peripheral channels (1..8)
//  REGION_BASE      32'h1000_0000 base of region 0; must be aligned to 2**REGION_SIZE_LOG2
//  REGION_SIZE_LOG2 24            log2 of bytes per region; regions are contiguous
//  TIMEOUT          255           max ACCESS cycles before error; 0 disables the timeout
// PORTS
//  clk          in  1        core clock
//  reset        in  1        synchronous, active-high reset
//  core_req     in  1        MEM stage presents a load/store this cycle
//  core_wr      in  1        1=store, 0=load
//  core_addr    in  32       byte address (MEM-stage ALU result)
//  core_wr_data in  32       store data
//  core_wstrb   in  4        store byte enables
//  core_stall   out 1        freeze pipeline (feeds the hazard unit as ~MEM_RDY)
//  core_resp    out 1        1-cycle pulse: the MMIO access has completed
//  core_rd_data out 32       load data, valid when core_resp=1
//  core_err     out 1        with core_resp: the access timed out
//  err_count    out 16       count of timeouts, saturates at 16'hFFFF
//  bus_cs       out N_REGIONS one-hot channel select
//  bus_wr       out 1        write strobe
//  bus_rd       out 1        read strobe
//  bus_addr     out 32       address offset within the region (base subtracted)
//  bus_wr_data  out 32       write data
//  bus_wstrb    out 4        byte enables
//  bus_rd_data  in  32*N     read data; channel i is on bits [32i+31:32i]
//  bus_ready    in  N_REGIONS per-channel completion
// BEHAVIOUR
//  hit = core_req and REGION_BASE <= core_addr < REGION_BASE + N_REGIONS<<REGION_SIZE_LOG2.
//  region = (core_addr-REGION_BASE)>>REGION_SIZE_LOG2. A miss is ignored: no stall, no bus activity.
//  FSM:
//   IDLE   : core_stall = hit (combinational). On hit, latch addr offset/data/wstrb/wr/region
//            and go to ACCESS.
//   ACCESS : bus_cs[region]=1; bus_wr=wr; bus_rd=~wr; all bus outputs come from registers and are
//            stable. core_stall=1; the timeout counter increments each ACCESS cycle.
//            If bus_ready[region]=1, capture rd_data (0 for writes) and go to RESP.
//            Else, if TIMEOUT!=0 and count==TIMEOUT-1, go to RESP with err=1.
//            Ready from unselected channels is ignored. Ready and timeout in the same cycle: ready wins.
//   RESP   : core_resp=1 and core_stall=0, so the pipeline advances this cycle.
//            core_err=err; err_count+1 if err. core_req is ignored. Next state is IDLE.
//  Timed-out load: core_rd_data=32'h0.
//  Minimum latency: request in IDLE at cycle 0, ready in cycle 1, core_resp in cycle 2.
//  Stall is high in cycles 0..1.
//  Outputs outside RESP: core_resp=0, core_err=0, core_rd_data holds its last value.
//  Reset (any state, including mid-ACCESS): next edge state=IDLE. All bus_* outputs=0.
//  core_stall=0, core_resp=0, core_err=0, core_rd_data=0, err_count=0, timeout counter=0.
//  The aborted access gets no response.
// TESTING
//  Load 0x1000_0010, ch0 ready after 3 wait cycles -> bus_addr=0x10; stall high 4 cycles;
//   core_resp with ch0 data 0xA5A5_0001.
//  Store 0x1300_0004, wstrb=0011, ch3 ready on first ACCESS cycle -> bus_cs=1000, bus_wr=1;
//   resp at cycle 2; core_rd_data=0.
//  Request to 0x0000_1000 or 0x1400_0000 -> no stall, bus_cs=0, no resp.
//  Load to ch1, never ready, TIMEOUT=255 -> 255 ACCESS cycles; resp with core_err=1, rd_data=0;
//   err_count=1.
//  ch2 selected, ch0 ready pulses -> ignored; completes only on ch2 ready.
//  Reset during ACCESS cycle 5 -> next cycle IDLE, bus_cs=0, stall=0; a new request proceeds normally.

Source files
------------

// File: rtl/mmio_bridge_multi_if.sv
// Core MEM-stage and peripheral-channel signals of the MMIO bridge.
// The master modport is the core/peripheral side; the bridge takes the slave modport.
interface mmio_bridge_multi_if #(
    parameter int N_REGIONS = 4
);
    logic                      core_req;
    logic                      core_wr;
    logic [31:0]               core_addr;
    logic [31:0]               core_wr_data;
    logic [3:0]                core_wstrb;
    logic                      core_stall;
    logic                      core_resp;
    logic [31:0]               core_rd_data;
    logic                      core_err;
    logic [15:0]               err_count;
    logic [N_REGIONS-1:0]      bus_cs;
    logic                      bus_wr;
    logic                      bus_rd;
    logic [31:0]               bus_addr;
    logic [31:0]               bus_wr_data;
    logic [3:0]                bus_wstrb;
    logic [32*N_REGIONS-1:0]   bus_rd_data;
    logic [N_REGIONS-1:0]      bus_ready;

    modport master (
        output core_req, core_wr, core_addr, core_wr_data, core_wstrb,
        output bus_rd_data, bus_ready,
        input  core_stall, core_resp, core_rd_data, core_err, err_count,
        input  bus_cs, bus_wr, bus_rd, bus_addr, bus_wr_data, bus_wstrb
    );

    modport slave (
        input  core_req, core_wr, core_addr, core_wr_data, core_wstrb,
        input  bus_rd_data, bus_ready,
        output core_stall, core_resp, core_rd_data, core_err, err_count,
        output bus_cs, bus_wr, bus_rd, bus_addr, bus_wr_data, bus_wstrb
    );
endinterface

// File: rtl/mmio_bridge_multi.sv
// Multi-region MMIO bridge: decodes the MEM-stage address onto one of N channels, waits for that channel's ready.
// Latency: request cycle, >=1 ACCESS cycle, then a 1-cycle RESP; the core is stalled until RESP, dead devices time out.
module mmio_bridge_multi #(
    parameter int          N_REGIONS        = 4,
    parameter logic [31:0] REGION_BASE      = 32'h1000_0000,
    parameter int          REGION_SIZE_LOG2 = 24,
    parameter int          TIMEOUT          = 255
) (
    input  logic clk,
    input  logic reset,
    mmio_bridge_multi_if.slave bif
);
    localparam int RW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0]   OFS_MASK = (32'h1 << REGION_SIZE_LOG2) - 32'h1;
    localparam logic [CW-1:0] TO_LAST  = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_e;

    state_e        state_q, state_d;
    logic [RW-1:0] region_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          wr_q;
    logic          err_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   rdata_q;
    logic [15:0]   err_count_q;

    logic [31:0]   offset;
    logic [31:0]   region_full;
    logic          hit;
    logic          sel_ready;
    logic [31:0]   sel_rdata;
    logic          timeout;

    // Subtraction wraps below the base, so the explicit >= test rejects those addresses.
    assign offset      = bif.core_addr - REGION_BASE;
    assign region_full = offset >> REGION_SIZE_LOG2;
    assign hit         = bif.core_req && (bif.core_addr >= REGION_BASE)
                         && (region_full < 32'(N_REGIONS));
    assign sel_ready   = bif.bus_ready[region_q];
    assign sel_rdata   = bif.bus_rd_data[32*int'(region_q) +: 32];
    assign timeout     = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (hit) state_d = S_ACCESS;
            S_ACCESS: if (sel_ready || timeout) state_d = S_RESP;
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            region_q    <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
            err_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        region_q <= RW'(region_full);
                        addr_q   <= bif.core_addr & OFS_MASK;
                        wdata_q  <= bif.core_wr_data;
                        wstrb_q  <= bif.core_wstrb;
                        wr_q     <= bif.core_wr;
                        cnt_q    <= '0;
                        err_q    <= 1'b0;
                    end
                end
                S_ACCESS: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Ready beats a same-cycle timeout.
                    if (sel_ready) begin
                        rdata_q <= wr_q ? 32'h0 : sel_rdata;
                        err_q   <= 1'b0;
                    end else if (timeout) begin
                        rdata_q <= 32'h0;
                        err_q   <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (err_q && (err_count_q != 16'hFFFF))
                        err_count_q <= err_count_q + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bif.core_stall   = 1'b0;
        bif.core_resp    = 1'b0;
        bif.core_err     = 1'b0;
        bif.core_rd_data = rdata_q;
        bif.err_count    = err_count_q;
        bif.bus_cs       = '0;
        bif.bus_wr       = 1'b0;
        bif.bus_rd       = 1'b0;
        bif.bus_addr     = addr_q;
        bif.bus_wr_data  = wdata_q;
        bif.bus_wstrb    = wstrb_q;
        case (state_q)
            S_IDLE:   bif.core_stall = hit;
            S_ACCESS: begin
                bif.core_stall       = 1'b1;
                bif.bus_cs[region_q] = 1'b1;
                bif.bus_wr           = wr_q;
                bif.bus_rd           = ~wr_q;
            end
            S_RESP: begin
                bif.core_resp = 1'b1;
                bif.core_err  = err_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mmio_bridge_multi.sv
// Randomized and directed bench for mmio_bridge_multi against a transaction-level reference model.
module tb_mmio_bridge_multi;
    localparam int          N    = 4;
    localparam int          TO   = 255;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] RSZ  = 32'h0100_0000;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fails  = 0;
    logic [15:0] exp_err_cnt = 16'h0;
    logic [31:0] exp_rd      = 32'h0;

    always #5 clk = ~clk;

    mmio_bridge_multi_if #(.N_REGIONS(N)) bif ();

    mmio_bridge_multi #(
        .N_REGIONS(N), .REGION_BASE(BASE), .REGION_SIZE_LOG2(24), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .bif(bif)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic bit model_hit(input logic [31:0] a);
        return (longint'(a) >= longint'(BASE)) &&
               (longint'(a) <  longint'(BASE) + longint'(N) * longint'(RSZ));
    endfunction

    task automatic drive_idle();
        bif.core_req     = 1'b0;
        bif.core_wr      = 1'b0;
        bif.core_addr    = 32'h0;
        bif.core_wr_data = 32'h0;
        bif.core_wstrb   = 4'h0;
        bif.bus_ready    = '0;
        bif.bus_rd_data  = '0;
    endtask

    // rdy_cyc: cycle (counted from the request) in which the selected channel raises ready; 0 = never.
    // junk: 0 none, 1 random ready on other channels, 2 all other channels ready every cycle.
    task automatic run_txn(input string nm, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input int rdy_cyc, input int junk, input logic [31:0] rdv);
        bit          hit, exp_to, stable;
        int          reg_i, resp_cyc, stall_cnt, exp_resp_cyc;
        logic [31:0] ofs, exp_data;
        logic [N-1:0] sel;
        hit = model_hit(addr);
        @(negedge clk);
        bif.core_req = 1'b1; bif.core_wr = wr; bif.core_addr = addr;
        bif.core_wr_data = wdata; bif.core_wstrb = strb; bif.bus_ready = '0;
        #1;
        check({nm, ".stall0"}, 32'(bif.core_stall), 32'(hit));
        if (!hit) begin
            @(negedge clk);
            check({nm, ".miss_cs"},    32'(bif.bus_cs), 32'h0);
            check({nm, ".miss_resp"},  32'(bif.core_resp), 32'h0);
            check({nm, ".miss_stall"}, 32'(bif.core_stall), 32'h0);
            bif.core_req = 1'b0;
            return;
        end
        reg_i        = int'((addr - BASE) / RSZ);
        ofs          = (addr - BASE) % RSZ;
        sel          = N'(1) << reg_i;
        exp_to       = (rdy_cyc == 0) || (rdy_cyc > TO);
        exp_resp_cyc = exp_to ? TO + 1 : rdy_cyc + 1;
        exp_data     = (exp_to || wr) ? 32'h0 : rdv;
        stall_cnt    = 1;
        resp_cyc     = 0;
        stable       = 1'b1;
        for (int k = 1; k <= TO + 10 && resp_cyc == 0; k++) begin
            @(negedge clk);
            if (bif.core_resp) begin
                resp_cyc = k;
                check({nm, ".err"},       32'(bif.core_err), 32'(exp_to));
                check({nm, ".rd_data"},   bif.core_rd_data, exp_data);
                check({nm, ".resp_stall"}, 32'(bif.core_stall), 32'h0);
                bif.core_req  = 1'b0;
                bif.bus_ready = '0;
            end else begin
                if (bif.core_stall) stall_cnt++;
                if (k == 1) begin
                    check({nm, ".cs"},    32'(bif.bus_cs), 32'(sel));
                    check({nm, ".addr"},  bif.bus_addr, ofs);
                    check({nm, ".rdwr"},  {30'h0, bif.bus_wr, bif.bus_rd}, {30'h0, wr, ~wr});
                    check({nm, ".wdata"}, bif.bus_wr_data, wdata);
                    check({nm, ".wstrb"}, 32'(bif.bus_wstrb), 32'(strb));
                end
                if (bif.bus_cs !== sel || bif.bus_addr !== ofs || bif.bus_wr !== wr ||
                    bif.bus_rd !== ~wr || bif.bus_wr_data !== wdata)
                    stable = 1'b0;
                for (int c = 0; c < N; c++) bif.bus_rd_data[32*c +: 32] = $urandom;
                if (k == rdy_cyc) bif.bus_rd_data[32*reg_i +: 32] = rdv;
                bif.bus_ready = (k == rdy_cyc) ? sel : '0;
                if (junk == 1) bif.bus_ready = bif.bus_ready | (N'($urandom) & ~sel);
                if (junk == 2) bif.bus_ready = bif.bus_ready | ~sel;
            end
        end
        bif.core_req  = 1'b0;
        bif.bus_ready = '0;
        check({nm, ".bus_stable"}, 32'(stable), 32'h1);
        check({nm, ".resp_cyc"},  32'(resp_cyc), 32'(exp_resp_cyc));
        check({nm, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_resp_cyc));
        if (exp_to && exp_err_cnt != 16'hFFFF) exp_err_cnt = exp_err_cnt + 16'd1;
        exp_rd = exp_data;
        @(negedge clk);
        check({nm, ".post_resp"},  {30'h0, bif.core_resp, bif.core_err}, 32'h0);
        check({nm, ".rd_hold"},    bif.core_rd_data, exp_rd);
        check({nm, ".err_count"},  32'(bif.err_count), 32'(exp_err_cnt));
        check({nm, ".post_stall"}, 32'(bif.core_stall), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          sel_kind;
        drive_idle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst.stall", 32'(bif.core_stall), 32'h0);
        check("rst.resp",  {30'h0, bif.core_resp, bif.core_err}, 32'h0);
        check("rst.rd",    bif.core_rd_data, 32'h0);
        check("rst.errc",  32'(bif.err_count), 32'h0);
        check("rst.bus",   {26'h0, bif.bus_cs, bif.bus_wr, bif.bus_rd}, 32'h0);
        check("rst.baddr", bif.bus_addr, 32'h0);
        reset = 1'b0;

        run_txn("ld_ch0",  32'h1000_0010, 1'b0, 32'h0,         4'hF, 3, 0, 32'hA5A5_0001);
        run_txn("st_ch3",  32'h1300_0004, 1'b1, 32'hDEAD_BEEF, 4'h3, 1, 0, 32'h1234_5678);
        run_txn("miss_lo", 32'h0000_1000, 1'b0, 32'h0,         4'hF, 1, 0, 32'h0);
        run_txn("miss_hi", 32'h1400_0000, 1'b1, 32'h1,         4'hF, 1, 0, 32'h0);
        run_txn("to_ch1",  32'h1100_0020, 1'b0, 32'h0,         4'hF, 0, 1, 32'h0);
        run_txn("junk_ch2", 32'h1200_0100, 1'b0, 32'h0,        4'hF, 4, 2, 32'h0BAD_F00D);
        run_txn("rdy_at_to", 32'h13FF_FFFC, 1'b0, 32'h0,       4'hF, TO, 0, 32'hCAFE_0255);

        // Reset in the fifth ACCESS cycle aborts the access without a response.
        @(negedge clk);
        bif.core_req = 1'b1; bif.core_wr = 1'b0; bif.core_addr = 32'h1200_0040;
        for (int k = 1; k <= 5; k++) @(negedge clk);
        check("abort.stall5", 32'(bif.core_stall), 32'h1);
        reset = 1'b1;
        bif.core_req = 1'b0;
        @(negedge clk);
        check("abort.cs",    32'(bif.bus_cs), 32'h0);
        check("abort.stall", 32'(bif.core_stall), 32'h0);
        check("abort.resp",  32'(bif.core_resp), 32'h0);
        check("abort.rd",    bif.core_rd_data, 32'h0);
        check("abort.errc",  32'(bif.err_count), 32'h0);
        reset = 1'b0;
        exp_err_cnt = 16'h0;
        exp_rd      = 32'h0;
        @(negedge clk);
        check("abort.noresp", 32'(bif.core_resp), 32'h0);
        run_txn("after_rst", 32'h1100_0008, 1'b0, 32'h0, 4'hF, 2, 1, 32'h7777_0002);

        for (int t = 0; t < 40; t++) begin
            sel_kind = $urandom_range(0, 9);
            if (sel_kind == 0)      a = $urandom_range(0, 32'h0FFF_FFFF);
            else if (sel_kind == 1) a = 32'h1400_0000 + $urandom_range(0, 32'h00FF_FFFF);
            else                    a = BASE + $urandom_range(0, N - 1) * RSZ + $urandom_range(0, 32'h00FF_FFFF);
            run_txn($sformatf("rnd%0d", t), a, 1'($urandom), $urandom, 4'($urandom),
                    $urandom_range(1, 8), $urandom_range(0, 1), $urandom);
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
